// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : melody_sequencer
//  Description : Note-select front end for the piezo tone generator. Passes
//                one-hot manual keys through in IDLE, or plays a 16-entry song
//                ROM with beat timing and an articulation gap between notes.
//  Revision    : 1.0  initial release
// ============================================================================
module melody_sequencer #(
    parameter int TICK_DIV   = 1000,
    parameter int BEAT_TICKS = 250,
    parameter int GAP_TICKS  = 20,
    parameter int DEB_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play_btn,
    input  logic        stop_btn,
    input  logic        loop_en,
    input  logic [11:0] sw_in,
    output logic [11:0] note_out,
    output logic        playing,
    output logic [3:0]  note_idx,
    output logic        song_done
);

    localparam int PRE_W = $clog2(TICK_DIV + 1);
    localparam int TCK_W = $clog2(7 * BEAT_TICKS + 1);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_NOTE = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Song ROM: {code[3:0], dur[2:0]}; code 0 is a rest.
    function automatic logic [6:0] rom_entry(input logic [3:0] a);
        case (a)
            4'd0:    return {4'd1, 3'd1};
            4'd1:    return {4'd1, 3'd1};
            4'd2:    return {4'd5, 3'd1};
            4'd3:    return {4'd5, 3'd1};
            4'd4:    return {4'd6, 3'd1};
            4'd5:    return {4'd6, 3'd1};
            4'd6:    return {4'd5, 3'd2};
            4'd7:    return {4'd0, 3'd1};
            4'd8:    return {4'd4, 3'd1};
            4'd9:    return {4'd4, 3'd1};
            4'd10:   return {4'd3, 3'd1};
            4'd11:   return {4'd3, 3'd1};
            4'd12:   return {4'd2, 3'd1};
            4'd13:   return {4'd2, 3'd1};
            4'd14:   return {4'd1, 3'd2};
            default: return {4'd0, 3'd1};
        endcase
    endfunction

    // Codes 1..12 select one tone bit; everything else is silence.
    function automatic logic [11:0] note_decode(input logic [3:0] code);
        if (code >= 4'd1 && code <= 4'd12) begin
            return 12'd1 << (code - 4'd1);
        end
        return 12'd0;
    endfunction

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = play, bit 1 = stop
    // ------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {stop_btn, play_btn};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             level_q;
        logic             level_d;
        logic [DEB_W-1:0] cnt_q;
        logic [DEB_W-1:0] cnt_d;
        logic             w_rise;

        // Accept a new level only after it has disagreed for DEB_CYCLES cycles in a row.
        always_comb begin
            level_d = level_q;
            cnt_d   = '0;
            w_rise  = 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                    level_d = sync2_q;
                    w_rise  = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Two-flop synchroniser plus debounce state.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= w_btn_raw[gi];
                sync2_q <= sync1_q;
                level_q <= level_d;
                cnt_q   <= cnt_d;
            end
        end

        assign w_press[gi] = w_rise;
    end

    logic w_play;
    logic w_stop;
    assign w_play = w_press[0];
    assign w_stop = w_press[1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [3:0]       idx_q,       idx_d;
    logic [3:0]       code_q,      code_d;
    logic [2:0]       dur_q,       dur_d;
    logic [PRE_W-1:0] presc_q,     presc_d;
    logic [TCK_W-1:0] tick_q,      tick_d;
    logic [11:0]      note_out_q,  note_out_d;
    logic             playing_q,   playing_d;
    logic             song_done_q, song_done_d;

    logic [6:0]  w_rom;
    logic [3:0]  w_rom_code;
    logic [2:0]  w_rom_dur;
    logic        w_active;
    logic        w_pre_wrap;
    logic [31:0] w_note_last;
    logic        w_note_end;
    logic        w_gap_end;
    logic        w_sw_onehot;

    assign w_rom       = rom_entry(idx_q);
    assign w_rom_code  = w_rom[6:3];
    assign w_rom_dur   = w_rom[2:0];
    assign w_active    = (state_q == S_LOAD) || (state_q == S_NOTE) || (state_q == S_GAP);
    assign w_pre_wrap  = (presc_q == PRE_W'(TICK_DIV - 1));
    assign w_note_last = 32'(dur_q) * 32'(BEAT_TICKS) - 32'(GAP_TICKS) - 32'd1;
    assign w_note_end  = w_pre_wrap && (32'(tick_q) == w_note_last);
    assign w_gap_end   = w_pre_wrap && (32'(tick_q) == 32'(GAP_TICKS - 1));
    assign w_sw_onehot = (sw_in != 12'd0) && ((sw_in & (sw_in - 12'd1)) == 12'd0);

    // Next state, song position and timing counters; counters restart on every NOTE/GAP entry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        dur_d   = dur_q;
        presc_d = '0;
        tick_d  = '0;
        if (w_active && w_stop) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
        end else if (w_play) begin
            state_d = S_LOAD;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_LOAD: begin
                    code_d  = w_rom_code;
                    dur_d   = (w_rom_dur == 3'd0) ? 3'd1 : w_rom_dur;
                    state_d = S_NOTE;
                end
                S_NOTE: begin
                    if (w_note_end) begin
                        state_d = S_GAP;
                    end else if (w_pre_wrap) begin
                        tick_d = tick_q + 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                        tick_d  = tick_q;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        if (idx_q != 4'd15) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_LOAD;
                        end else if (loop_en) begin
                            idx_d   = 4'd0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (w_pre_wrap) begin
                        tick_d = tick_q + 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                        tick_d  = tick_q;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                end
            endcase
        end
    end

    // Outputs follow the next state so they switch on the same edge as the state register.
    always_comb begin
        note_out_d  = 12'd0;
        playing_d   = (state_d == S_LOAD) || (state_d == S_NOTE) || (state_d == S_GAP);
        song_done_d = (state_d == S_DONE);
        case (state_d)
            S_IDLE:  note_out_d = w_sw_onehot ? sw_in : 12'd0;
            S_NOTE:  note_out_d = note_decode(code_d);
            default: note_out_d = 12'd0;
        endcase
    end

    // State and output registers; reset forces silence and IDLE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            code_q      <= 4'd0;
            dur_q       <= 3'd0;
            presc_q     <= '0;
            tick_q      <= '0;
            note_out_q  <= 12'd0;
            playing_q   <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            dur_q       <= dur_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            note_out_q  <= note_out_d;
            playing_q   <= playing_d;
            song_done_q <= song_done_d;
        end
    end

    assign note_out  = note_out_q;
    assign playing   = playing_q;
    assign note_idx  = idx_q;
    assign song_done = song_done_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_melody_sequencer
//  Description : Self-checking bench for melody_sequencer (small timing
//                parameters). Expected outputs are queued as stimulus is
//                driven and compared one edge later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_melody_sequencer;

    localparam int TD = 4;
    localparam int BT = 5;
    localparam int GT = 1;
    localparam int DB = 3;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        play_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic        loop_en  = 1'b0;
    logic [11:0] sw_in    = 12'd0;
    logic [11:0] note_out;
    logic        playing;
    logic [3:0]  note_idx;
    logic        song_done;

    melody_sequencer #(
        .TICK_DIV   (TD),
        .BEAT_TICKS (BT),
        .GAP_TICKS  (GT),
        .DEB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play_btn  (play_btn),
        .stop_btn  (stop_btn),
        .loop_en   (loop_en),
        .sw_in     (sw_in),
        .note_out  (note_out),
        .playing   (playing),
        .note_idx  (note_idx),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]     note;
        logic            playing;
        logic [3:0]      idx;
        logic            chk_idx;
        logic            done;
        logic [8*10-1:0] tag;
    } exp_t;

    typedef struct {
        logic [11:0] sw;
        logic [11:0] exp_note;
    } man_vec_t;

    exp_t     sb[$];
    exp_t     e_chk;
    man_vec_t tbl[8];
    int       n_tests   = 0;
    int       n_fail    = 0;
    int       play_hold = 0;
    int       stop_hold = 0;

    int c_code[16] = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2, 1, 0};
    int c_dur[16]  = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 2, 1};

    function automatic logic [11:0] tone(input int code);
        if (code >= 1 && code <= 12) return 12'(1) << (code - 1);
        return 12'h000;
    endfunction

    function automatic logic [11:0] pass(input logic [11:0] sw);
        return ($countones(sw) == 1) ? sw : 12'h000;
    endfunction

    function automatic exp_t mk(input logic [11:0] note, input logic pl, input int idx,
                                input logic chk_idx, input logic done, input logic [79:0] tag);
        exp_t e;
        e.note    = note;
        e.playing = pl;
        e.idx     = 4'(idx);
        e.chk_idx = chk_idx;
        e.done    = done;
        e.tag     = tag;
        return e;
    endfunction

    task automatic check(input exp_t e);
        n_tests++;
        if (note_out !== e.note || playing !== e.playing || song_done !== e.done ||
            (e.chk_idx && note_idx !== e.idx)) begin
            n_fail++;
            $display("FAIL %s @%0t: got note_out=%h playing=%b note_idx=%0d song_done=%b, want %h %b %0d%s %b",
                     e.tag, $time, note_out, playing, note_idx, song_done,
                     e.note, e.playing, e.idx, e.chk_idx ? "" : "(any)", e.done);
        end
    endtask

    // Scoreboard consumer: compare each queued expectation just after its edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e_chk = sb.pop_front();
            check(e_chk);
        end
    end

    // Queue the expectation for the coming edge, then advance to the next negedge.
    task automatic step(input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        if (play_hold > 0) begin
            play_hold--;
            if (play_hold == 0) play_btn = 1'b0;
        end
        if (stop_hold > 0) begin
            stop_hold--;
            if (stop_hold == 0) stop_btn = 1'b0;
        end
    endtask

    // Play press from IDLE: synchroniser + debounce delay puts LOAD on the 5th edge.
    task automatic press_play(input logic [11:0] sw);
        play_btn  = 1'b1;
        play_hold = 6;
        repeat (4) step(mk(pass(sw), 1'b0, 0, 1'b1, 1'b0, "press"));
    endtask

    task automatic load_note(input int i, input int n);
        step(mk(12'h000, 1'b1, i, 1'b1, 1'b0, "load"));
        repeat (n) step(mk(tone(c_code[i]), 1'b1, i, 1'b1, 1'b0, "note"));
    endtask

    task automatic entry(input int i);
        load_note(i, (c_dur[i] * BT - GT) * TD);
        repeat (GT * TD) step(mk(12'h000, 1'b1, i, 1'b1, 1'b0, "gap"));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{12'h010, 12'h010};
        tbl[1] = '{12'h011, 12'h000};
        tbl[2] = '{12'h000, 12'h000};
        tbl[3] = '{12'h800, 12'h800};
        tbl[4] = '{12'h001, 12'h001};
        tbl[5] = '{12'hFFF, 12'h000};
        tbl[6] = '{12'h400, 12'h400};
        tbl[7] = '{12'h003, 12'h000};

        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check(mk(12'h000, 1'b0, 0, 1'b1, 1'b0, "reset"));
        reset = 1'b1;

        // Manual passthrough table
        for (int i = 0; i < 8; i++) begin
            sw_in = tbl[i].sw;
            step(mk(tbl[i].exp_note, 1'b0, 0, 1'b1, 1'b0, "manual"));
        end

        // Short play pulse is rejected by the debouncer
        sw_in     = 12'h000;
        play_btn  = 1'b1;
        play_hold = 2;
        repeat (10) step(mk(12'h000, 1'b0, 0, 1'b1, 1'b0, "deb_short"));

        // Full song without looping: 376 cycles LOAD to DONE, single done pulse
        loop_en = 1'b0;
        press_play(12'h000);
        for (int i = 0; i < 16; i++) entry(i);
        step(mk(12'h000, 1'b0, 0, 1'b0, 1'b1, "done"));
        repeat (3) step(mk(12'h000, 1'b0, 0, 1'b1, 1'b0, "post_done"));

        // Looping song; sw_in must be ignored while playing
        loop_en = 1'b1;
        sw_in   = 12'h020;
        press_play(sw_in);
        for (int i = 0; i < 16; i++) entry(i);
        entry(0);
        entry(1);
        entry(2);

        // Stop mid-note at idx 3
        load_note(3, 2);
        stop_btn  = 1'b1;
        stop_hold = 6;
        repeat (4) step(mk(tone(c_code[3]), 1'b1, 3, 1'b1, 1'b0, "note"));
        step(mk(12'h020, 1'b0, 0, 1'b1, 1'b0, "stop"));
        repeat (8) step(mk(12'h020, 1'b0, 0, 1'b1, 1'b0, "stop_idle"));

        // Play and stop pressed together: stop wins
        press_play(sw_in);
        load_note(0, 8);
        play_btn  = 1'b1;
        stop_btn  = 1'b1;
        play_hold = 6;
        stop_hold = 6;
        repeat (4) step(mk(tone(c_code[0]), 1'b1, 0, 1'b1, 1'b0, "note"));
        step(mk(12'h020, 1'b0, 0, 1'b1, 1'b0, "both"));
        repeat (8) step(mk(12'h020, 1'b0, 0, 1'b1, 1'b0, "both_idle"));

        // Play while playing restarts the song from idx 0
        press_play(sw_in);
        entry(0);
        entry(1);
        load_note(2, 3);
        play_btn  = 1'b1;
        play_hold = 6;
        repeat (4) step(mk(tone(c_code[2]), 1'b1, 2, 1'b1, 1'b0, "note"));
        for (int i = 0; i < 5; i++) entry(i);
        load_note(5, 3);

        // Asynchronous reset during NOTE at idx 5
        reset = 1'b0;
        #1;
        check(mk(12'h000, 1'b0, 0, 1'b1, 1'b0, "async_rst"));
        @(negedge clk);
        reset = 1'b1;
        sw_in = 12'h100;
        step(mk(12'h100, 1'b0, 0, 1'b1, 1'b0, "post_rst"));
        sw_in = 12'h003;
        step(mk(12'h000, 1'b0, 0, 1'b1, 1'b0, "post_rst2"));

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the piezo tone generator: produces the 12-bit one-hot note-select bus that the tone generator converts to a square wave.
- Two modes:
  - Manual: switch keys pass straight through to the note bus.
  - Auto-play: a built-in 16-entry song ROM is stepped with beat timing and an articulation gap between notes.
- Play and stop buttons are synchronised and debounced internally.

Parameters:
- TICK_DIV, 1000: clk cycles per timing tick.
- BEAT_TICKS, 250: ticks per beat.
- GAP_TICKS, 20: silent ticks at the end of every note. Must satisfy 1 <= GAP_TICKS < BEAT_TICKS.
- DEB_CYCLES, 1000: consecutive stable clk cycles needed to accept a button level change.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_btn  in  1  raw play button, active-high, asynchronous
- stop_btn  in  1  raw stop button, active-high, asynchronous
- loop_en  in  1  1 = restart song after the last entry
- sw_in  in  12  manual note keys, bit k = note k+1
- note_out  out  12  one-hot note select to the tone generator; 0 = silence
- playing  out  1  high in LOAD, NOTE and GAP states
- note_idx  out  4  current ROM index
- song_done  out  1  one-cycle pulse when a non-looping song completes

Behaviour:
- Reset values:
  - note_out=0, playing=0, note_idx=0, song_done=0.
  - FSM=IDLE, all counters 0, debounced levels 0.
- Button conditioning, per button:
  - 2-flop synchroniser.
  - Debounced level updates only after the synchronised value has differed from it for DEB_CYCLES consecutive cycles. A mismatch shorter than that resets the stability counter.
  - A 0->1 debounced transition gives a one-cycle press pulse.
- Song ROM entry format: {code[3:0], dur[2:0]}.
  - code 1..12 drives one-hot bit code-1.
  - code 0 and codes 13..15 are rests (note_out=0).
  - dur 0 is treated as 1.
- ROM contents, idx 0..15:
  - codes: 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0
  - durs: 1,1,1,1,1,1,2,1,1,1,1,1,1,1,2,1
- FSM states: IDLE, LOAD, NOTE, GAP, DONE.
  - IDLE: note_out = sw_in if exactly one bit is set, else 0. play press -> LOAD with idx=0.
  - LOAD (1 cycle): latch ROM[idx] -> NOTE.
  - NOTE: note_out = decoded code. Lasts exactly (dur*BEAT_TICKS - GAP_TICKS)*TICK_DIV cycles -> GAP.
  - GAP: note_out=0. Lasts exactly GAP_TICKS*TICK_DIV cycles. Then:
    - idx<15: idx+1 -> LOAD.
    - idx=15 and loop_en=1: idx=0 -> LOAD.
    - idx=15 and loop_en=0: -> DONE.
  - DONE (1 cycle): song_done=1, idx=0 -> IDLE.
- Tick counting: the tick prescaler (0..TICK_DIV-1) and the tick counter clear on every entry to NOTE or GAP, so durations are exact, not tick-aligned.
- note_out, playing, note_idx are registered and change on the same edge as the state register.
- Stop press in LOAD/NOTE/GAP -> IDLE next edge, idx=0, no song_done. Manual passthrough resumes from that edge.
- Play press in LOAD/NOTE/GAP restarts: -> LOAD with idx=0.
- Play and stop press in the same cycle: stop wins.
- Stop press in IDLE has no effect.
- loop_en is sampled only at GAP exit of idx 15.
- sw_in is ignored in all states except IDLE.
- Async reset mid-song: immediate silence and return to IDLE.

Test Plan (TICK_DIV=4, BEAT_TICKS=5, GAP_TICKS=1, DEB_CYCLES=3):
- Manual mode: sw_in=12'h010 -> note_out=12'h010 next edge; sw_in=12'h011 -> note_out=0; sw_in=0 -> 0.
- Debounce: play_btn high 2 cycles then low -> no press, stays IDLE. play_btn high 6 cycles -> exactly one LOAD entry, playing=1.
- Timing: after play, idx0 gives note_out=12'h001 for 16 cycles then 0 for 4 cycles. idx6 gives 12'h010 for 36 cycles. Full song, loop_en=0, takes 376 cycles from LOAD entry to DONE; song_done is a single pulse; note_idx returns to 0.
- Loop: loop_en=1 -> after idx15 GAP, idx=0 LOAD, no song_done, note_out=12'h001 again.
- Stop mid-note at idx3 -> next edge IDLE, note_out=sw_in value, playing=0, song_done=0. Play and stop pressed in the same cycle -> IDLE.
- Reset asserted during NOTE at idx5 -> note_out=0, note_idx=0, playing=0 immediately. After release, manual mode is active.
